// File: rtl/inet_checksum_stream.sv
// ---------------------------------------------------------------------------
// inet_checksum_stream
//   Streaming RFC 1071 ones-complement checksum over a byte stream delivered
//   IN_BYTES bytes per beat. Handles a partial final beat, odd total length
//   (final byte zero-padded in the low half of its word), a seeded start
//   value (e.g. a pseudo-header partial sum) and a verify flag.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   start      begin a new packet; loads init as the running sum
//   init       16-bit seed partial sum, sampled on start
//   inclk      input beat valid
//   in         beat data; byte 0 is the most significant byte
//   in_last    this beat is the final beat of the packet
//   in_nbytes  number of valid bytes on the final beat (0..IN_BYTES)
//   busy       folding / presenting the result; inclk is ignored
//   outclk     one-cycle result strobe
//   out        ~folded sum (value for the checksum field), held until next result
//   ok         folded sum == 16'hffff (received data verifies), held likewise
// ---------------------------------------------------------------------------
module inet_checksum_stream #(
  parameter  int IN_BYTES = 4,
  parameter  int ACC_LEN  = 32,
  localparam int NB_W     = $clog2(IN_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             init,
  input  logic                    inclk,
  input  logic [IN_BYTES*8-1:0]   in,
  input  logic                    in_last,
  input  logic [NB_W-1:0]         in_nbytes,
  output logic                    busy,
  output logic                    outclk,
  output logic [15:0]             out,
  output logic                    ok
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_FOLD1 = 3'd2,
    ST_FOLD2 = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [ACC_LEN-1:0]   acc_q, acc_d;
  logic                 phase_q, phase_d;
  logic                 busy_q, busy_d;
  logic                 outclk_q, outclk_d;
  logic [15:0]          out_q, out_d;
  logic                 ok_q, ok_d;

  logic                 base_phase;
  int                   n_valid;
  logic [7:0]           byte_val;
  logic [ACC_LEN-1:0]   contrib;
  logic [ACC_LEN-1:0]   beat_sum;
  logic                 phase_after;
  logic [ACC_LEN-1:0]   acc_lo;
  logic [ACC_LEN-1:0]   acc_hi;
  logic [ACC_LEN-1:0]   fold;

  // Sum of the current beat's valid bytes, each placed high or low in its
  // 16-bit word by its stream position parity. A beat taken together with
  // start is at stream position 0, so it ignores the stored phase.
  always_comb begin
    beat_sum    = '0;
    byte_val    = 8'h00;
    contrib     = '0;
    base_phase  = start ? 1'b0 : phase_q;
    n_valid     = in_last ? int'(in_nbytes) : IN_BYTES;
    for (int i = 0; i < IN_BYTES; i++) begin
      byte_val = (i < n_valid) ? in[IN_BYTES*8-1-8*i -: 8] : 8'h00;
      contrib  = ((base_phase ^ i[0]) == 1'b0)
               ? {{(ACC_LEN-16){1'b0}}, byte_val, 8'h00}
               : {{(ACC_LEN-8){1'b0}}, byte_val};
      beat_sum = beat_sum + contrib;
    end
    phase_after = base_phase ^ n_valid[0];
  end

  // End-around carry: low 16 bits plus everything above them.
  always_comb begin
    acc_lo = {{(ACC_LEN-16){1'b0}}, acc_q[15:0]};
    acc_hi = {16'h0000, acc_q[ACC_LEN-1:16]};
    fold   = acc_lo + acc_hi;
  end

  // Next-state, accumulator and result computation.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    phase_d = phase_q;
    out_d   = out_q;
    ok_d    = ok_q;
    if (start) begin
      // New packet from any state; an in-flight fold is simply dropped.
      acc_d   = {{(ACC_LEN-16){1'b0}}, init} + (inclk ? beat_sum : {ACC_LEN{1'b0}});
      phase_d = inclk ? phase_after : 1'b0;
      state_d = (inclk && in_last) ? ST_FOLD1 : ST_ACCUM;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ACCUM: begin
          if (inclk) begin
            acc_d   = fold + beat_sum;
            phase_d = phase_after;
            state_d = in_last ? ST_FOLD1 : ST_ACCUM;
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_FOLD1: begin
          acc_d   = fold;
          state_d = ST_FOLD2;
        end
        ST_FOLD2: begin
          // Second fold leaves at most 16 bits; capture the result now so
          // out/ok are registered in the same edge that enters DONE.
          acc_d   = fold;
          out_d   = ~fold[15:0];
          ok_d    = (fold[15:0] == 16'hffff);
          state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d   = (state_d == ST_FOLD1) || (state_d == ST_FOLD2) || (state_d == ST_DONE);
    outclk_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      phase_q  <= 1'b0;
      busy_q   <= 1'b0;
      outclk_q <= 1'b0;
      out_q    <= 16'h0000;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      phase_q  <= phase_d;
      busy_q   <= busy_d;
      outclk_q <= outclk_d;
      out_q    <= out_d;
      ok_q     <= ok_d;
    end
  end

  assign busy   = busy_q;
  assign outclk = outclk_q;
  assign out    = out_q;
  assign ok     = ok_q;

endmodule

// File: tb/tb_inet_checksum_stream.sv
// ---------------------------------------------------------------------------
// tb_inet_checksum_stream
//   Three instances (1-, 3- and 4-byte beats) share one stimulus bus; `sel`
//   routes start/inclk to the instance under test. A packet-level model
//   (byte queue + ones-complement arithmetic) predicts every result, and
//   literal hand-computed values pin the model.
// ---------------------------------------------------------------------------
module tb_inet_checksum_stream;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start_b;
  logic [15:0] init_b;
  logic        inclk_b;
  logic [31:0] in_bus;
  logic        last_b;
  logic [2:0]  nb_bus;
  int          sel;

  logic [2:0]  start_v, inclk_v;
  logic [2:0]  busy_v, outclk_v, ok_v;
  logic [15:0] out_v [3];

  always #5 clk = ~clk;

  assign start_v[0] = start_b && (sel == 0);
  assign start_v[1] = start_b && (sel == 1);
  assign start_v[2] = start_b && (sel == 2);
  assign inclk_v[0] = inclk_b && (sel == 0);
  assign inclk_v[1] = inclk_b && (sel == 1);
  assign inclk_v[2] = inclk_b && (sel == 2);

  inet_checksum_stream #(.IN_BYTES(1), .ACC_LEN(32)) u_dut1 (
    .clk(clk), .rst(rst_b), .start(start_v[0]), .init(init_b), .inclk(inclk_v[0]),
    .in(in_bus[31:24]), .in_last(last_b), .in_nbytes(nb_bus[0:0]),
    .busy(busy_v[0]), .outclk(outclk_v[0]), .out(out_v[0]), .ok(ok_v[0]));

  inet_checksum_stream #(.IN_BYTES(3), .ACC_LEN(32)) u_dut3 (
    .clk(clk), .rst(rst_b), .start(start_v[1]), .init(init_b), .inclk(inclk_v[1]),
    .in(in_bus[31:8]), .in_last(last_b), .in_nbytes(nb_bus[1:0]),
    .busy(busy_v[1]), .outclk(outclk_v[1]), .out(out_v[1]), .ok(ok_v[1]));

  inet_checksum_stream #(.IN_BYTES(4), .ACC_LEN(32)) u_dut4 (
    .clk(clk), .rst(rst_b), .start(start_v[2]), .init(init_b), .inclk(inclk_v[2]),
    .in(in_bus), .in_last(last_b), .in_nbytes(nb_bus),
    .busy(busy_v[2]), .outclk(outclk_v[2]), .out(out_v[2]), .ok(ok_v[2]));

  // ---------------- packet model ----------------
  int          cyc;
  bit          active;
  bit          pending;
  int          exp_cycle;
  logic [15:0] exp_out;
  logic        exp_ok;
  logic [15:0] seed;
  logic [7:0]  pkt [$];
  logic [15:0] held_out [3];
  logic        held_ok  [3];
  int          n_checks;
  int          n_fail;
  bit          chk_en;
  bit          es, eb;

  logic [7:0]  hdr  [20];
  logic [7:0]  hdr2 [20];

  function automatic int lane_bytes(input int s);
    return (s == 0) ? 1 : (s == 1) ? 3 : 4;
  endfunction

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
    end
  endfunction

  // Whole-packet ones-complement sum: even positions are word high bytes.
  function automatic void model_result();
    int unsigned s;
    s = {16'h0000, seed};
    for (int i = 0; i < pkt.size(); i++)
      s += ((i % 2) == 0) ? {16'h0000, pkt[i], 8'h00} : {24'h000000, pkt[i]};
    while ((s >> 16) != 0) s = (s & 32'h0000ffff) + (s >> 16);
    exp_out = ~s[15:0];
    exp_ok  = (s[15:0] == 16'hffff);
  endfunction

  task automatic step(input logic s, input logic [15:0] ini, input logic ic,
                      input logic [31:0] d, input logic l, input int nb);
    int n;
    start_b = s; init_b = ini; inclk_b = ic; in_bus = d; last_b = l; nb_bus = nb[2:0];
    @(posedge clk);
    if (rst_b) begin
      active = 0; pending = 0;
      for (int k = 0; k < 3; k++) begin held_out[k] = 16'h0000; held_ok[k] = 1'b0; end
    end else begin
      if (pending && (cyc == exp_cycle - 1) && !s) begin
        held_out[sel] = exp_out; held_ok[sel] = exp_ok;
      end
      if (pending && (cyc == exp_cycle)) pending = 0;
      if (s) begin seed = ini; pkt.delete(); active = 1; pending = 0; end
      if (ic && active) begin
        n = l ? nb : lane_bytes(sel);
        for (int i = 0; i < n; i++) pkt.push_back(d[31-8*i -: 8]);
        if (l) begin
          model_result();
          exp_cycle = cyc + 3;
          pending = 1;
          active = 0;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 0);
  endtask

  // Per-cycle comparison of the selected instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      es = pending && (cyc == exp_cycle);
      eb = pending && (cyc >= exp_cycle - 2) && (cyc <= exp_cycle);
      check("outclk", {31'h0, outclk_v[sel]}, {31'h0, es});
      check("busy",   {31'h0, busy_v[sel]},   {31'h0, eb});
      check("out",    {16'h0, out_v[sel]},    {16'h0, held_out[sel]});
      check("ok",     {31'h0, ok_v[sel]},     {31'h0, held_ok[sel]});
    end
  end

  initial begin
    hdr = '{8'h45,8'h00,8'h01,8'h66,8'h71,8'h8a,8'h00,8'h00,8'h80,8'h11,
            8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'hff,8'hff,8'hff,8'hff};
    hdr2 = hdr;
    hdr2[10] = 8'hc7; hdr2[11] = 8'hfd;
    n_checks = 0; n_fail = 0; chk_en = 0; cyc = 0; sel = 0;
    active = 0; pending = 0; exp_cycle = -10;
    rst_b = 1'b1;
    idle(2);
    rst_b = 1'b0;
    chk_en = 1;
    for (int k = 0; k < 3; k++) begin
      check("reset out", {16'h0, out_v[k]}, 32'h0);
      check("reset ok",  {31'h0, ok_v[k]},  32'h0);
    end

    // T1: 1-byte beats, 20-byte header.
    sel = 0;
    step(1'b1, 16'h0000, 1'b0, 32'h0, 1'b0, 0);
    for (int i = 0; i < 20; i++) step(1'b0, 16'h0, 1'b1, {hdr[i], 24'h0}, (i == 19), 1);
    idle(4);
    check("T1 out", {16'h0, out_v[0]}, 32'h0000c7fd);
    check("T1 ok",  {31'h0, ok_v[0]},  32'h0);

    // T2: 4-byte beats, start and first beat in the same cycle; then verify.
    sel = 2;
    for (int b = 0; b < 5; b++)
      step((b == 0), 16'h0000, 1'b1, {hdr[4*b], hdr[4*b+1], hdr[4*b+2], hdr[4*b+3]}, (b == 4), 4);
    idle(4);
    check("T2 out", {16'h0, out_v[2]}, 32'h0000c7fd);
    for (int b = 0; b < 5; b++)
      step((b == 0), 16'h0000, 1'b1, {hdr2[4*b], hdr2[4*b+1], hdr2[4*b+2], hdr2[4*b+3]}, (b == 4), 4);
    idle(4);
    check("T2 verify out", {16'h0, out_v[2]}, 32'h0);
    check("T2 verify ok",  {31'h0, ok_v[2]},  32'h1);

    // T3: partial last beat (3 bytes) and an empty last beat with junk data.
    step(1'b1, 16'h0000, 1'b1, 32'h01020300, 1'b1, 3);
    idle(4);
    check("T3 nbytes3", {16'h0, out_v[2]}, 32'h0000fbfd);
    step(1'b1, 16'h0000, 1'b0, 32'h0, 1'b0, 0);
    step(1'b0, 16'h0000, 1'b1, 32'h01020000, 1'b0, 0);
    step(1'b0, 16'h0000, 1'b1, 32'hdeadbeef, 1'b1, 0);
    idle(4);
    check("T3 nbytes0", {16'h0, out_v[2]}, 32'h0000fefd);

    // T4: 3-byte beats carry odd phase across beats; words 0102+0304+0506 = 090c.
    sel = 1;
    step(1'b1, 16'h0000, 1'b0, 32'h0, 1'b0, 0);
    step(1'b0, 16'h0000, 1'b1, 32'h01020300, 1'b0, 0);
    step(1'b0, 16'h0000, 1'b1, 32'h04050600, 1'b1, 3);
    idle(4);
    check("T4 odd phase", {16'h0, out_v[1]}, 32'h0000f6f3);
    step(1'b1, 16'h1234, 1'b1, 32'h0001ff00, 1'b1, 2);
    idle(4);
    check("T4 seeded", {16'h0, out_v[1]}, 32'h0000edca);

    // T5: all-ones data, then start in the DONE cycle.
    sel = 2;
    step(1'b1, 16'h0000, 1'b0, 32'h0, 1'b0, 0);
    step(1'b0, 16'h0000, 1'b1, 32'hffffffff, 1'b0, 0);
    step(1'b0, 16'h0000, 1'b1, 32'hffffffff, 1'b1, 4);
    idle(2);
    check("T5 out", {16'h0, out_v[2]}, 32'h0);
    check("T5 ok",  {31'h0, ok_v[2]},  32'h1);
    step(1'b1, 16'h0000, 1'b0, 32'h0, 1'b0, 0);
    step(1'b0, 16'h0000, 1'b1, 32'h01020300, 1'b1, 3);
    idle(4);
    check("T5 back-to-back", {16'h0, out_v[2]}, 32'h0000fbfd);

    // T6: start during FOLD1 aborts; beats while busy are ignored.
    step(1'b1, 16'h0000, 1'b1, 32'h11223300, 1'b1, 3);
    step(1'b1, 16'h0000, 1'b0, 32'h0, 1'b0, 0);
    step(1'b0, 16'h0000, 1'b1, 32'h00010000, 1'b1, 4);
    step(1'b0, 16'h0000, 1'b1, 32'hffffffff, 1'b1, 4);
    step(1'b0, 16'h0000, 1'b1, 32'hffffffff, 1'b1, 4);
    idle(3);
    check("T6 abort+busy", {16'h0, out_v[2]}, 32'h0000fffe);

    // Reset mid-fold.
    step(1'b1, 16'h0000, 1'b1, 32'h01020300, 1'b1, 3);
    idle(1);
    rst_b = 1'b1;
    idle(1);
    rst_b = 1'b0;
    check("rst fold out",  {16'h0, out_v[2]}, 32'h0);
    check("rst fold busy", {31'h0, busy_v[2]}, 32'h0);
    idle(4);

    // Reset mid-packet, then a beat in IDLE that must be ignored.
    step(1'b1, 16'h0000, 1'b1, 32'hffffffff, 1'b0, 0);
    rst_b = 1'b1;
    idle(1);
    rst_b = 1'b0;
    step(1'b0, 16'h0000, 1'b1, 32'hffffffff, 1'b1, 4);
    idle(4);
    check("rst pkt out", {16'h0, out_v[2]}, 32'h0);
    check("rst pkt ok",  {31'h0, ok_v[2]},  32'h0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
